// File: rtl/halflife_pkg.sv
// Shared types and helpers for the half-life decay timer.
package halflife_pkg;

    typedef enum logic [0:0] {StIdle, StDecay} state_e;

    // A programmed period of zero behaves as a one-cycle half-life.
    localparam int unsigned PeriodZeroSub = 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
        return (v >= max_v) ? max_v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hl_prescaler.sv
// Cycle counter that pulses tick on the last cycle of each half-life period.
module hl_prescaler #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic [PW-1:0] per,
    output logic          tick
);

    logic [PW-1:0] cnt_q;

    assign tick = en && (cnt_q == per - PW'(1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + PW'(1);
        end
    end

endmodule

// File: rtl/halflife_timer.sv
// Up/down/load counter with an autonomous decay mode that halves the count
// once per programmable period until it falls to or below a threshold.
module halflife_timer
    import halflife_pkg::*;
#(
    parameter int unsigned W    = 8,
    parameter int unsigned PW   = 8,
    parameter int unsigned HW   = 4,
    parameter int unsigned WRAP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up,
    input  logic          down,
    input  logic          load,
    input  logic [W-1:0]  load_val,
    input  logic          start,
    input  logic [PW-1:0] period,
    input  logic [W-1:0]  thresh,
    output logic [W-1:0]  count,
    output logic [HW-1:0] halvings,
    output logic          busy,
    output logic          done
);

    localparam logic [W-1:0] CntMax = '1;
    localparam logic [31:0]  HMax   = 32'((64'd1 << HW) - 64'd1);

    state_e        state_q, state_d;
    logic [W-1:0]  count_q, count_d;
    logic [HW-1:0] halv_q, halv_d;
    logic [PW-1:0] per_q, per_d;
    logic [W-1:0]  thr_q, thr_d;
    logic          done_q, done_d;
    logic          fin_q, fin_d;
    logic [W-1:0]  halved;
    logic          tick;

    hl_prescaler #(
        .PW (PW)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == StDecay),
        .clr  (state_q == StIdle),
        .per  (per_q),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            count_q <= '0;
            halv_q  <= '0;
            per_q   <= PW'(PeriodZeroSub);
            thr_q   <= '0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            halv_q  <= halv_d;
            per_q   <= per_d;
            thr_q   <= thr_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        halv_d  = halv_q;
        per_d   = per_q;
        thr_d   = thr_q;
        // fin_q delays the end-of-decay pulse so done never overlaps busy.
        done_d  = fin_q;
        fin_d   = 1'b0;
        halved  = count_q >> 1;
        case (state_q)
            StIdle: begin
                if (load) begin
                    count_d = load_val;
                end else if (start) begin
                    per_d  = (period == '0) ? PW'(PeriodZeroSub) : period;
                    thr_d  = thresh;
                    halv_d = '0;
                    if (count_q <= thresh) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StDecay;
                    end
                end else if (up && !down) begin
                    if (WRAP != 0 || count_q != CntMax) begin
                        count_d = count_q + W'(1);
                    end
                end else if (down && !up) begin
                    if (WRAP != 0 || count_q != '0) begin
                        count_d = count_q - W'(1);
                    end
                end
            end
            StDecay: begin
                if (load) begin
                    count_d = load_val;
                    state_d = StIdle;
                end else if (tick) begin
                    count_d = halved;
                    halv_d  = HW'(sat_inc(32'(halv_q), HMax));
                    if (halved <= thr_q) begin
                        state_d = StIdle;
                        fin_d   = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        count    = count_q;
        halvings = halv_q;
        busy     = (state_q == StDecay);
        done     = done_q;
    end

endmodule

// File: doc/halflife_timer.md
Name: halflife_timer

Overview:
- Parametrised successor to the 4-bit half-life up/down/load counter.
- Adds a width-generic saturating or wrapping up/down/load counter, plus an autonomous decay mode. In decay mode the held value is halved every programmable number of clock cycles (the "half-life") until it falls to or below a threshold.
- Sits beside the display/IO logic and is driven by the board buttons or by a host register interface.

Parameters:
- W, 8, counter width in bits (2..32).
- PW, 8, half-life period field width in bits.
- HW, 4, halving-count field width in bits.
- WRAP, 0, 0 = up/down saturate at the bounds; 1 = up/down wrap modulo 2^W.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- up  in  1  increment request (IDLE only).
- down  in  1  decrement request (IDLE only).
- load  in  1  load request; takes load_val.
- load_val  in  W  value captured on load.
- start  in  1  begin decay (IDLE only).
- period  in  PW  half-life length in clock cycles; sampled on start.
- thresh  in  W  decay terminates when count <= thresh; sampled on start.
- count  out  W  current counter value.
- halvings  out  HW  number of halvings in the current or last decay; saturates at 2^HW-1.
- busy  out  1  high while in DECAY.
- done  out  1  one-cycle pulse when a decay completes.

Behaviour:
- Reset (rst == 0 at a clock edge): count = 0, halvings = 0, busy = 0, done = 0, state = IDLE, prescaler = 0. Takes priority over every other input, including mid-decay.
- States: IDLE, DECAY. done is registered and is never high in the same cycle as busy.
- IDLE, per-cycle priority:
  - load: count <= load_val.
  - else start: see decay entry below.
  - else up & ~down: count + 1.
  - else down & ~up: count - 1.
  - else (including up & down together): hold.
- Up/down bounds:
  - WRAP = 0: up at 2^W-1 holds; down at 0 holds.
  - WRAP = 1: modulo 2^W arithmetic.
- Decay entry (start in IDLE):
  - Latch per = (period == 0) ? 1 : period.
  - Latch thr = thresh.
  - halvings <= 0; prescaler <= 0.
  - If count <= thresh already: stay IDLE, pulse done next cycle, halvings = 0.
  - Otherwise: state <= DECAY, busy <= 1.
- DECAY:
  - prescaler increments every cycle.
  - When prescaler == per-1: count <= count >> 1 (logical shift), halvings <= sat(halvings + 1), prescaler <= 0.
  - If the new count <= thr: state <= IDLE, busy <= 0, and done pulses for one cycle on the following edge.
- Latency: with start asserted at edge 0, the k-th halving is visible after edge k*per.
- In DECAY, up, down and start are ignored.
- load in DECAY aborts: count <= load_val, state <= IDLE, busy <= 0, done stays 0, halvings keeps its value.
- thr >= 2^W-1 cannot occur in DECAY because entry requires count > thr. The decay always terminates, because count reaches 0 within W halvings.
- Changing period or thresh during DECAY has no effect until the next start.

Decomposition:
- halflife_pkg holds:
  - state enum {IDLE, DECAY};
  - localparam for the period == 0 substitution value (1);
  - saturating-increment function for halvings.
- One natural sub-module, hl_prescaler: a PW-bit cycle counter with clear and terminal-count pulse (tick when cnt == per-1).
- Counter, FSM and done logic stay in halflife_timer.

Test Plan:
- Reset mid-decay: load 200, start period 5, pull rst low at cycle 7 -> next edge count = 0, halvings = 0, busy = 0, done = 0.
- Full decay: W=8, load 200, thresh 0, period 3, start at edge 0 -> count sequence 100, 50, 25, 12, 6, 3, 1, 0 at edges 3, 6, …, 24; halvings = 8; busy falls at edge 24; done high for exactly one cycle after that.
- Threshold stop: load 160, thresh 20, period 1 -> 80, 40, 20, then stop; halvings = 3; done pulses once.
- Saturation/wrap:
  - WRAP=0, load 255, up -> 255; load 0, down -> 0.
  - WRAP=1: 255 + up -> 0.
  - up and down together -> hold.
- Corner starts:
  - period 0 behaves as 1.
  - start with count 5 and thresh 9 -> no DECAY, done pulse, halvings = 0.
  - load 77 during DECAY -> count = 77, IDLE, no done.
- Priority: load together with start and up in IDLE -> count = load_val, state stays IDLE.
